// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared UART definitions for the receive path; the transmitter uses the
// same constants. Provides the receiver state encoding, the oversampling
// constants, the default divider and the 3-sample majority vote helper.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE      = 16;
  localparam int SAMPLE_MID      = 8;
  localparam int DEFAULT_DIVIDER = 39;
  localparam int SC_WIDTH        = $clog2(OVERSAMPLE);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Groups the serial input, configuration, RX FIFO push and status signals
// of the UART receiver.
//   slave  : the receiver (consumes rx_bit/config, drives data/status)
//   master : the surrounding system (pad, register block, FIFO)
interface uart_rx_if #(
  parameter int DIV_WIDTH = 8,
  parameter int DATA_BITS = 8
);
  logic                 rx_bit;
  logic [DIV_WIDTH-1:0] freq_divider;
  logic                 fifo_full;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun_err;

  modport slave (
    input  rx_bit, freq_divider, fifo_full, err_clr,
    output rx_data, rx_valid, rx_busy, frame_err, overrun_err
  );

  modport master (
    output rx_bit, freq_divider, fifo_full, err_clr,
    input  rx_data, rx_valid, rx_busy, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Produces the 16x oversampling tick: one-clk pulse every
// i_freq_divider+1 clocks. Shared between the RX and TX paths.
//   clk            : system clock
//   reset          : asynchronous, active-high reset
//   i_freq_divider : tick period minus 1, in clk cycles
//   o_tick         : one-clk tick pulse
module uart_baud_tick #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] i_freq_divider,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_hit;

  // Compared against the live divider, so a new value applies at the next compare.
  assign w_hit = (r_cnt == i_freq_divider);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cnt <= '0;
    else if (w_hit) r_cnt <= '0;
    else            r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = w_hit;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// UART 8N1 receiver. Synchronizes rx_bit, oversamples at 16x, takes the
// majority of samples 7/8/9 of every bit, assembles data LSB-first and
// pushes each good byte to the RX FIFO with a one-clk rx_valid strobe.
// Sticky frame_err (stop bit low) and overrun_err (good byte dropped on
// fifo_full) are cleared by err_clr; a same-cycle set wins.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : uart_rx_if.slave (rx_bit, freq_divider, fifo_full, err_clr,
//           rx_data, rx_valid, rx_busy, frame_err, overrun_err)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int DATA_BITS = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int                  IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [SC_WIDTH-1:0] SC_S1    = SC_WIDTH'(SAMPLE_MID - 1);
  localparam logic [SC_WIDTH-1:0] SC_S2    = SC_WIDTH'(SAMPLE_MID);
  localparam logic [SC_WIDTH-1:0] SC_S3    = SC_WIDTH'(SAMPLE_MID + 1);

  logic                 r_sync1, r_sync2;
  uart_state_e          r_state, w_next_state;
  logic [SC_WIDTH-1:0]  r_sc;
  logic                 r_samp_a, r_samp_b;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr, r_ovr;

  logic w_tick, w_rxs, w_mid, w_maj;
  logic w_busy, w_shift_en, w_good, w_ovr_set, w_ferr_set;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud_tick (
    .clk            (clk),
    .reset          (reset),
    .i_freq_divider (bus.freq_divider),
    .o_tick         (w_tick)
  );

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx_bit;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;
  // Third sample is taken live at the evaluation tick.
  assign w_mid = w_tick && (r_sc == SC_S3);
  assign w_maj = majority3(r_samp_a, r_samp_b, w_rxs);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_tick && !w_rxs)            w_next_state = ST_START;
      ST_START: if (w_mid)                       w_next_state = w_maj ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_mid && (r_idx == LAST_IDX)) w_next_state = ST_STOP;
      ST_STOP:  if (w_mid)                       w_next_state = ST_IDLE;
      default:                                   w_next_state = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_shift_en = 1'b0;
    w_good     = 1'b0;
    w_ovr_set  = 1'b0;
    w_ferr_set = 1'b0;
    if (r_state == ST_DATA) w_shift_en = w_mid;
    if ((r_state == ST_STOP) && w_mid) begin
      w_good     =  w_maj && !bus.fifo_full;
      w_ovr_set  =  w_maj &&  bus.fifo_full;
      w_ferr_set = !w_maj;
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc     <= '0;
      r_samp_a <= 1'b1;
      r_samp_b <= 1'b1;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      // sc rests at 0 in IDLE so the detecting tick leaves START at sc=0.
      if (r_state == ST_IDLE) r_sc <= '0;
      else if (w_tick)        r_sc <= r_sc + 1'b1;

      if (w_tick && (r_sc == SC_S1)) r_samp_a <= w_rxs;
      if (w_tick && (r_sc == SC_S2)) r_samp_b <= w_rxs;

      if (r_state == ST_START) r_idx <= '0;
      else if (w_shift_en)     r_idx <= r_idx + 1'b1;

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};

      if (w_good) r_data <= r_shift;
      r_valid <= w_good;

      if (w_ferr_set)       r_ferr <= 1'b1;
      else if (bus.err_clr) r_ferr <= 1'b0;

      if (w_ovr_set)        r_ovr <= 1'b1;
      else if (bus.err_clr) r_ovr <= 1'b0;
    end
  end

  assign bus.rx_data     = r_data;
  assign bus.rx_valid    = r_valid;
  assign bus.rx_busy     = w_busy;
  assign bus.frame_err   = r_ferr;
  assign bus.overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Scoreboard bench for uart_rx: frames are pushed into an expected queue
// when issued; a monitor pops and compares on every rx_valid strobe.
module tb_uart_rx;

  localparam int DIV     = 3;
  localparam int BIT_CLK = (DIV + 1) * 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_if #(.DIV_WIDTH(8), .DATA_BITS(8)) u_if ();

  uart_rx #(.DIV_WIDTH(8), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_ferr, m_ovr;
  logic       prev_valid = 1'b0;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one frame from its byte, stop level and FIFO state.
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic full);
    if (stop && !full) begin
      exp_q.push_back(b);
      m_data = b;
    end else if (stop) begin
      m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b);
    u_if.rx_bit = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap_bits);
    model_frame(b, stop, u_if.fifo_full);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
  endtask

  task automatic pulse_err_clr();
    u_if.err_clr = 1'b1;
    @(negedge clk);
    u_if.err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      chk("valid_one_clk", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=0x%0h expected=none", u_if.rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rx_data_push", u_if.rx_data, mon_exp);
      end
    end
    prev_valid = u_if.rx_valid;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       stop, full;
    int         gap;

    u_if.rx_bit       = 1'b1;
    u_if.freq_divider = 8'(DIV);
    u_if.fifo_full    = 1'b0;
    u_if.err_clr      = 1'b0;
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rx_data",  u_if.rx_data, 0);
    chk("rst_rx_valid", u_if.rx_valid, 0);
    chk("rst_rx_busy",  u_if.rx_busy, 0);
    chk("rst_frame",    u_if.frame_err, 0);
    chk("rst_overrun",  u_if.overrun_err, 0);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);

    // 0x55, clean stop; busy must drop between 600 and 640 clk after the edge.
    model_frame(8'h55, 1'b1, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h55 >> i));
    u_if.rx_bit = 1'b1;
    repeat (24) @(negedge clk);
    chk("busy_before_midstop", u_if.rx_busy, 1);
    repeat (40) @(negedge clk);
    chk("busy_after_midstop", u_if.rx_busy, 0);
    chk("frame_55", u_if.frame_err, 0);
    chk("data_55", u_if.rx_data, 8'h55);
    repeat (BIT_CLK) @(negedge clk);
    chk("drained_55", exp_q.size(), 0);

    // 12-clk low glitch on idle line
    u_if.rx_bit = 1'b0;
    repeat (12) @(negedge clk);
    u_if.rx_bit = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy_seen", u_if.rx_busy, 1);
    repeat (BIT_CLK) @(negedge clk);
    chk("glitch_busy_idle", u_if.rx_busy, 0);
    chk("glitch_frame", u_if.frame_err, 0);
    chk("glitch_overrun", u_if.overrun_err, 0);
    chk("glitch_data", u_if.rx_data, m_data);

    // Framing error, then clear
    send_frame(8'hA3, 1'b0, 2);
    chk("ferr_set", u_if.frame_err, m_ferr);
    chk("ferr_data_kept", u_if.rx_data, m_data);
    chk("ferr_drained", exp_q.size(), 0);
    pulse_err_clr();
    chk("ferr_cleared", u_if.frame_err, 0);

    // Overrun, then a good frame
    u_if.fifo_full = 1'b1;
    send_frame(8'h0F, 1'b1, 1);
    chk("ovr_set", u_if.overrun_err, m_ovr);
    chk("ovr_data_kept", u_if.rx_data, m_data);
    u_if.fifo_full = 1'b0;
    send_frame(8'hF0, 1'b1, 1);
    chk("ovr_data_f0", u_if.rx_data, m_data);
    chk("ovr_sticky", u_if.overrun_err, 1);
    chk("ovr_drained", exp_q.size(), 0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1);
    chk("b2b_data", u_if.rx_data, m_data);
    chk("b2b_drained", exp_q.size(), 0);

    // Reset after data bit 3 of 0x81
    chk("pre_reset_overrun", u_if.overrun_err, m_ovr);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    reset = 1'b1;
    #1;
    chk("mid_rst_data",    u_if.rx_data, 0);
    chk("mid_rst_valid",   u_if.rx_valid, 0);
    chk("mid_rst_busy",    u_if.rx_busy, 0);
    chk("mid_rst_frame",   u_if.frame_err, 0);
    chk("mid_rst_overrun", u_if.overrun_err, 0);
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    u_if.rx_bit = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    chk("post_rst_busy", u_if.rx_busy, 0);
    send_frame(8'h3C, 1'b1, 1);
    chk("post_rst_data", u_if.rx_data, m_data);
    chk("post_rst_drained", exp_q.size(), 0);

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      u_if.fifo_full = full;
      send_frame(b, stop, gap);
      chk("rand_frame",   u_if.frame_err, m_ferr);
      chk("rand_overrun", u_if.overrun_err, m_ovr);
      chk("rand_data",    u_if.rx_data, m_data);
      if ($urandom_range(0, 2) == 0) pulse_err_clr();
    end
    u_if.fifo_full = 1'b0;

    repeat (BIT_CLK) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_busy", u_if.rx_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive path, the counterpart to the existing UART transmitter. It oversamples the asynchronous serial line at 16x the baud rate and validates the start bit at mid-bit. It assembles 8N1 frames LSB-first and presents each good byte as a one-cycle push into the RX FIFO. It sits between the rx_bit pad and the RX FIFO / Wishbone register block, and reports framing and overrun errors.

Parameters:
DIV_WIDTH, 8, width of freq_divider and the internal divide counter
DATA_BITS, 8, data bits per frame (only 8 is verified)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_bit  input  1  serial line; idle high; asynchronous to clk
freq_divider  input  DIV_WIDTH  16x tick period minus 1, in clk cycles (tick every freq_divider+1 clks)
fifo_full  input  1  RX FIFO full; sampled when a frame completes
err_clr  input  1  one-cycle pulse; clears frame_err and overrun_err
rx_data  output  8  last received byte; held until the next good frame
rx_valid  output  1  one-cycle push strobe to the RX FIFO
rx_busy  output  1  high in any state other than IDLE
frame_err  output  1  sticky; stop bit sampled low
overrun_err  output  1  sticky; good frame dropped because fifo_full was high

Behaviour:
- Reset (async, active-high): state=IDLE, synchronizer flops=1, divide counter=0, tick counter=0, bit index=0, shift register=0. Outputs: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0. A reset mid-frame discards the partial frame; no strobe is issued.
- Input sync: 2-flop synchronizer on rx_bit. All logic uses the synced value rxs.
- Tick generator: the counter increments each clk. When counter==freq_divider, tick=1 for one clk and the counter returns to 0. A freq_divider change takes effect at the next compare. Software changes it only while rx_busy=0; a frame in flight during a change is undefined.
- Sample counter: 4-bit sc advances on each tick and wraps 15->0. A bit value is the majority of rxs sampled on the ticks where sc=7, 8 and 9.
- FSM, evaluated on tick only (except the strobe):
  IDLE: rxs==0 on a tick -> START with sc=0.
  START: at sc==9, evaluate the majority. If 1 (glitch), go to IDLE with no error. If 0, go to DATA with sc counting on and bit index=0.
  DATA: at each sc==9, shift the majority into the MSB (LSB-first assembly) and increment the bit index. After the 8th bit, go to STOP.
  STOP: at sc==9, evaluate the majority.
    - If 1 and fifo_full=0: rx_data<=byte, and rx_valid=1 on the next clk for exactly one clk.
    - If 1 and fifo_full=1: overrun_err<=1; rx_data and rx_valid are unchanged.
    - If 0: frame_err<=1; no strobe.
    - In all three cases go to IDLE. This happens at mid-stop-bit, so a start edge that follows immediately is still caught.
- Simultaneous err_clr and a new error in the same cycle: the set wins.
- Latency: rx_valid rises 9.5 bit periods plus 2-3 clk (sync + strobe) after the falling start edge reaches rx_bit.
- Arithmetic: all counters wrap modulo their width. No saturation is required.

Decomposition:
- Shared package or include (uart_defs): state encodings IDLE/START/DATA/STOP, OVERSAMPLE=16, SAMPLE_MID=8, and default divider 39. The TX side also uses these constants.
- Sub-module uart_baud_tick: divider producing the 16x tick, reusable by TX.
- The FSM, majority vote and error flags live in uart_rx. The FIFO stays external.

Test Plan:
- freq_divider=3 (bit = 64 clk). Send 0x55 with a clean stop -> exactly one rx_valid pulse, rx_data=0x55, frame_err=0, rx_busy falls at mid-stop.
- Low glitch of 12 clk (3 ticks) on an idle line -> no rx_valid, FSM returns to IDLE, no error flags.
- Send 0xA3 with stop bit forced 0 -> frame_err=1, no rx_valid, rx_data keeps its previous value. Then pulse err_clr -> frame_err=0.
- Hold fifo_full=1 and send 0x0F -> overrun_err=1, no rx_valid. Release fifo_full and send 0xF0 -> rx_valid once, rx_data=0xF0, overrun_err stays 1.
- Back-to-back 0x00 then 0xFF with a single stop bit and no idle gap -> two rx_valid pulses with data 0x00, 0xFF.
- Assert reset after data bit 3 of 0x81 -> all outputs 0 immediately, no strobe. Then send 0x3C -> rx_data=0x3C, one rx_valid.
